// File: rtl/star_scheduler.sv
// Falling-star slot scheduler: once per video frame moves every star down, checks
// each slot against the TA box with one shared comparator, spawns, then reports hits.
module star_scheduler #(
  parameter int         N_STARS      = 4,
  parameter int         STAR_W       = 20,
  parameter int         STAR_H       = 20,
  parameter int         SCREEN_W     = 640,
  parameter int         SCREEN_H     = 480,
  parameter int         FALL_SPEED   = 2,
  parameter int         SPAWN_PERIOD = 30,
  parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_frame_tick,
  input  logic                    i_enable,
  input  logic [9:0]              i_ta_h,
  input  logic [9:0]              i_ta_v,
  input  logic [9:0]              i_ta_width,
  input  logic [9:0]              i_ta_height,
  output logic [10*N_STARS-1:0]   o_star_h_flat,
  output logic [10*N_STARS-1:0]   o_star_v_flat,
  output logic [N_STARS-1:0]      o_star_valid,
  output logic                    o_star_hit,
  output logic [7:0]              o_hit_count,
  output logic                    o_busy
);

  localparam int               IDX_W       = (N_STARS > 1) ? $clog2(N_STARS) : 1;
  localparam int               TMR_W       = $clog2(SPAWN_PERIOD) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_STARS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(SPAWN_PERIOD - 1);
  localparam logic [10:0]      SCREEN_H_L  = 11'(SCREEN_H);
  localparam logic [10:0]      FALL_L      = 11'(FALL_SPEED);
  localparam logic [10:0]      STAR_W_L    = 11'(STAR_W);
  localparam logic [10:0]      STAR_H_L    = 11'(STAR_H);
  localparam logic [9:0]       SPAWN_RANGE = 10'(SCREEN_W - STAR_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_CHECK = 3'd2,
    ST_SPAWN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [9:0]           r_h [N_STARS];
  logic [9:0]           r_v [N_STARS];
  logic [N_STARS-1:0]   r_valid;
  logic [IDX_W-1:0]     r_slot;
  logic [TMR_W-1:0]     r_timer;
  logic [9:0]           r_lfsr;
  logic                 r_frame_hit;
  logic                 r_star_hit;
  logic [7:0]           r_hit_count;
  logic                 r_busy;

  logic [10:0]          w_v_moved [N_STARS];
  logic [9:0]           w_cur_h;
  logic [9:0]           w_cur_v;
  logic                 w_hit;
  logic [9:0]           w_lfsr_next;
  logic [9:0]           w_spawn_h;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_any_free;
  logic                 w_timer_due;
  logic                 w_do_spawn;

  // Fibonacci LFSR for x^10 + x^7 + 1; a non-zero state never reaches zero.
  function automatic logic [9:0] lfsr_step(input logic [9:0] s);
    lfsr_step = {s[8:0], s[9] ^ s[6]};
  endfunction

  function automatic logic [IDX_W-1:0] lowest_free(input logic [N_STARS-1:0] v);
    lowest_free = '0;
    for (int i = N_STARS - 1; i >= 0; i--) begin
      if (!v[i]) begin
        lowest_free = IDX_W'(i);
      end
    end
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    sat_inc = (c == 8'hFF) ? 8'hFF : c + 8'd1;
  endfunction

  // Frame sequencer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; enable only matters when a frame is about to start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_frame_tick && i_enable) begin
          w_state_next = ST_MOVE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_MOVE:  w_state_next = ST_CHECK;
      ST_CHECK: begin
        if (r_slot == IDX_LAST) begin
          w_state_next = ST_SPAWN;
        end else begin
          w_state_next = ST_CHECK;
        end
      end
      ST_SPAWN: w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Candidate fall positions, one bit wider so the bottom edge can be detected.
  always_comb begin
    for (int i = 0; i < N_STARS; i++) begin
      w_v_moved[i] = {1'b0, r_v[i]} + FALL_L;
    end
  end

  // Shared overlap comparator for the slot selected this CHECK cycle.
  always_comb begin
    w_cur_h = r_h[r_slot];
    w_cur_v = r_v[r_slot];
    w_hit   = r_valid[r_slot]
            && ({1'b0, i_ta_h} < ({1'b0, w_cur_h} + STAR_W_L))
            && (({1'b0, i_ta_h} + {1'b0, i_ta_width}) > {1'b0, w_cur_h})
            && ({1'b0, i_ta_v} < ({1'b0, w_cur_v} + STAR_H_L))
            && (({1'b0, i_ta_v} + {1'b0, i_ta_height}) > {1'b0, w_cur_v});
  end

  // Spawn decision and horizontal position folded into the visible range.
  always_comb begin
    w_lfsr_next = lfsr_step(r_lfsr);
    w_free_idx  = lowest_free(r_valid);
    w_any_free  = ~&r_valid;
    w_timer_due = (r_timer >= TMR_LAST);
    w_do_spawn  = (r_state == ST_SPAWN) && w_timer_due && w_any_free;
    if (w_lfsr_next < SPAWN_RANGE) begin
      w_spawn_h = w_lfsr_next;
    end else begin
      w_spawn_h = w_lfsr_next - SPAWN_RANGE;
    end
  end

  // Slot storage: fall/retire in MOVE, clear on hit in CHECK, fill in SPAWN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < N_STARS; i++) begin
        r_h[i] <= 10'd0;
        r_v[i] <= 10'd0;
      end
    end else begin
      case (r_state)
        ST_MOVE: begin
          for (int i = 0; i < N_STARS; i++) begin
            if (r_valid[i]) begin
              if (w_v_moved[i] >= SCREEN_H_L) begin
                r_valid[i] <= 1'b0;
              end else begin
                r_v[i] <= w_v_moved[i][9:0];
              end
            end
          end
        end
        ST_CHECK: begin
          if (w_hit) begin
            r_valid[r_slot] <= 1'b0;
          end
        end
        ST_SPAWN: begin
          if (w_do_spawn) begin
            r_valid[w_free_idx] <= 1'b1;
            r_h[w_free_idx]     <= w_spawn_h;
            r_v[w_free_idx]     <= 10'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Comparator slot pointer walks 0..N_STARS-1 during CHECK.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot <= '0;
    end else if (r_state == ST_CHECK) begin
      r_slot <= (r_slot == IDX_LAST) ? '0 : r_slot + IDX_W'(1);
    end else begin
      r_slot <= '0;
    end
  end

  // Per-frame hit flag, reported as a single-cycle pulse during DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_hit <= 1'b0;
      r_star_hit  <= 1'b0;
    end else begin
      r_star_hit <= (r_state == ST_SPAWN) ? r_frame_hit : 1'b0;
      if (r_state == ST_CHECK && w_hit) begin
        r_frame_hit <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_frame_hit <= 1'b0;
      end
    end
  end

  // Saturating running total of hits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_count <= 8'd0;
    end else if (r_state == ST_CHECK && w_hit) begin
      r_hit_count <= sat_inc(r_hit_count);
    end
  end

  // Spawn timer holds at its last value while all slots are full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (r_state == ST_SPAWN) begin
      if (w_timer_due) begin
        r_timer <= w_any_free ? '0 : TMR_LAST;
      end else begin
        r_timer <= r_timer + TMR_W'(1);
      end
    end
  end

  // Random source advances once per frame, whether or not a star spawns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_state == ST_SPAWN) begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // Busy is registered from the next state so it aligns with MOVE..DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
    end
  end

  for (genvar g = 0; g < N_STARS; g++) begin : g_flat
    assign o_star_h_flat[10*g +: 10] = r_h[g];
    assign o_star_v_flat[10*g +: 10] = r_v[g];
  end

  assign o_star_valid = r_valid;
  assign o_star_hit   = r_star_hit;
  assign o_hit_count  = r_hit_count;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_star_scheduler.sv
// Directed self-checking bench for star_scheduler: spawn timing, falling, retire,
// collision edges, busy overlap, full-slot spawn hold and asynchronous reset.
module tb_star_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  ta_h = 10'd0, ta_v = 10'd0, ta_w = 10'd0, ta_ht = 10'd0;
  logic [39:0] h_flat, v_flat;
  logic [3:0]  valid;
  logic        star_hit, busy;
  logic [7:0]  hit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  star_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(frame_tick), .i_enable(enable),
    .i_ta_h(ta_h), .i_ta_v(ta_v), .i_ta_width(ta_w), .i_ta_height(ta_ht),
    .o_star_h_flat(h_flat), .o_star_v_flat(v_flat), .o_star_valid(valid),
    .o_star_hit(star_hit), .o_hit_count(hit_count), .o_busy(busy)
  );

  function automatic logic [9:0] hv(input logic [39:0] f, input int i);
    return f[10*i +: 10];
  endfunction

  // Expected spawn h after n LFSR advances from the reset seed.
  function automatic logic [9:0] spawn_h_after(input int n);
    logic [9:0] s;
    s = 10'h2A5;
    for (int k = 0; k < n; k++) s = {s[8:0], s[9] ^ s[6]};
    return (s < 10'd620) ? s : s - 10'd620;
  endfunction

  task automatic do_reset();
    frame_tick = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_frame();
    int n;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_timeout: busy=%0b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic run_frames(input int n);
    for (int k = 0; k < n; k++) run_frame();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, h_flat, v_flat, star_hit, hit_count, busy} !== 94'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b hit_count=%0d busy=%b star_hit=%b, want all 0", valid, hit_count, busy, star_hit);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: busy=%b valid=%b, want 0/0000", busy, valid);
    end
  endtask

  task automatic test_spawn();
    do_reset();
    enable = 1'b1; ta_h = 10'd0; ta_v = 10'd0; ta_w = 10'd1; ta_ht = 10'd1;
    run_frames(29);
    checks++;
    if (valid !== 4'b0000) begin
      errors++; $display("FAIL spawn_early: valid=%b, want 0000", valid);
    end
    run_frame();
    checks++;
    if (valid !== 4'b0001 || hv(v_flat, 0) !== 10'd0) begin
      errors++; $display("FAIL spawn_first: valid=%b v0=%0d, want 0001/0", valid, hv(v_flat, 0));
    end
    checks++;
    if (hv(h_flat, 0) !== spawn_h_after(30) || hv(h_flat, 0) >= 10'd620) begin
      errors++; $display("FAIL spawn_h0: got %0d, want %0d (<620)", hv(h_flat, 0), spawn_h_after(30));
    end
    for (int k = 31; k <= 59; k++) begin
      run_frame();
      checks++;
      if (hv(v_flat, 0) !== 10'(2 * (k - 30)) || valid !== 4'b0001) begin
        errors++; $display("FAIL fall_v0: frame %0d v0=%0d valid=%b, want %0d/0001", k, hv(v_flat, 0), valid, 2 * (k - 30));
      end
    end
    run_frame();
    checks++;
    if (valid !== 4'b0011 || hv(v_flat, 0) !== 10'd60 || hv(v_flat, 1) !== 10'd0) begin
      errors++; $display("FAIL spawn_second: valid=%b v0=%0d v1=%0d, want 0011/60/0", valid, hv(v_flat, 0), hv(v_flat, 1));
    end
    checks++;
    if (hv(h_flat, 1) !== spawn_h_after(60)) begin
      errors++; $display("FAIL spawn_h1: got %0d, want %0d", hv(h_flat, 1), spawn_h_after(60));
    end
  endtask

  task automatic test_collision_edge();
    do_reset();
    ta_h = 10'd0; ta_v = 10'd100; ta_w = 10'd640; ta_ht = 10'd20;
    run_frames(70);
    checks++;
    if (valid !== 4'b0011 || hv(v_flat, 0) !== 10'd80 || hit_count !== 8'd0) begin
      errors++; $display("FAIL touch_no_hit: valid=%b v0=%0d hits=%0d, want 0011/80/0", valid, hv(v_flat, 0), hit_count);
    end
    @(negedge clk); frame_tick = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk); frame_tick = 1'b0;
      checks++;
      if (busy !== (c <= 7) || star_hit !== (c == 7)) begin
        errors++; $display("FAIL hit_timing: c%0d busy=%b star_hit=%b, want %b/%b", c, busy, star_hit, c <= 7, c == 7);
      end
    end
    checks++;
    if (valid !== 4'b0010 || hit_count !== 8'd1 || hv(v_flat, 1) !== 10'd22) begin
      errors++; $display("FAIL hit_result: valid=%b hits=%0d v1=%0d, want 0010/1/22", valid, hit_count, hv(v_flat, 1));
    end
  endtask

  task automatic test_busy_overlap();
    @(negedge clk); frame_tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      frame_tick = (c == 3) ? 1'b1 : 1'b0;
      checks++;
      if (busy !== (c <= 7)) begin
        errors++; $display("FAIL overlap_busy: c%0d busy=%b, want %b", c, busy, c <= 7);
      end
    end
    checks++;
    if (hv(v_flat, 1) !== 10'd24 || valid !== 4'b0010 || hit_count !== 8'd1) begin
      errors++; $display("FAIL overlap_update: v1=%0d valid=%b hits=%0d, want 24/0010/1", hv(v_flat, 1), valid, hit_count);
    end
  endtask

  task automatic test_retire();
    logic saw_hit;
    do_reset();
    ta_h = 10'd0; ta_v = 10'd0; ta_w = 10'd0; ta_ht = 10'd0;
    run_frames(269);
    checks++;
    if (valid !== 4'b1111 || hv(v_flat, 0) !== 10'd478 || hv(v_flat, 1) !== 10'd418) begin
      errors++; $display("FAIL pre_retire: valid=%b v0=%0d v1=%0d, want 1111/478/418", valid, hv(v_flat, 0), hv(v_flat, 1));
    end
    saw_hit = 1'b0;
    @(negedge clk); frame_tick = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk); frame_tick = 1'b0;
      saw_hit = saw_hit | star_hit;
      if (c == 2) begin
        checks++;
        if (valid !== 4'b1110) begin
          errors++; $display("FAIL retire_clear: valid=%b after MOVE, want 1110", valid);
        end
      end
    end
    checks++;
    if (saw_hit !== 1'b0 || hit_count !== 8'd0) begin
      errors++; $display("FAIL retire_no_hit: star_hit seen=%b hits=%0d, want 0/0", saw_hit, hit_count);
    end
    checks++;
    if (valid !== 4'b1111 || hv(v_flat, 0) !== 10'd0 || hv(h_flat, 0) !== spawn_h_after(270) || hv(v_flat, 1) !== 10'd420) begin
      errors++; $display("FAIL retire_respawn: valid=%b v0=%0d h0=%0d v1=%0d, want 1111/0/%0d/420", valid, hv(v_flat, 0), hv(h_flat, 0), hv(v_flat, 1), spawn_h_after(270));
    end
  endtask

  task automatic test_full_slots();
    do_reset();
    ta_h = 10'd0; ta_v = 10'd0; ta_w = 10'd0; ta_ht = 10'd0;
    run_frames(151);
    checks++;
    if (valid !== 4'b1111 || hv(v_flat, 2) !== 10'd122 || hv(v_flat, 3) !== 10'd62) begin
      errors++; $display("FAIL full_hold: valid=%b v2=%0d v3=%0d, want 1111/122/62", valid, hv(v_flat, 2), hv(v_flat, 3));
    end
    ta_v = 10'd124; ta_w = 10'd640; ta_ht = 10'd1;
    @(negedge clk); frame_tick = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk); frame_tick = 1'b0;
      if (c == 6) begin
        checks++;
        if (valid !== 4'b1011) begin
          errors++; $display("FAIL full_hit_clear: valid=%b before SPAWN, want 1011", valid);
        end
      end
      if (c == 7) begin
        checks++;
        if (star_hit !== 1'b1) begin
          errors++; $display("FAIL full_hit_pulse: star_hit=%b at c7, want 1", star_hit);
        end
      end
    end
    checks++;
    if (valid !== 4'b1111 || hv(v_flat, 2) !== 10'd0 || hv(h_flat, 2) !== spawn_h_after(152)) begin
      errors++; $display("FAIL full_refill: valid=%b v2=%0d h2=%0d, want 1111/0/%0d", valid, hv(v_flat, 2), hv(h_flat, 2), spawn_h_after(152));
    end
    checks++;
    if (hit_count !== 8'd1 || hv(v_flat, 0) !== 10'd244 || hv(v_flat, 1) !== 10'd184 || hv(v_flat, 3) !== 10'd64) begin
      errors++; $display("FAIL full_others: hits=%0d v0=%0d v1=%0d v3=%0d, want 1/244/184/64", hit_count, hv(v_flat, 0), hv(v_flat, 1), hv(v_flat, 3));
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, h_flat, v_flat, star_hit, hit_count, busy} !== 94'd0) begin
      errors++; $display("FAIL midframe_reset: valid=%b hits=%0d busy=%b star_hit=%b, want all 0", valid, hit_count, busy, star_hit);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      checks++;
      if (busy !== 1'b0 || star_hit !== 1'b0) begin
        errors++; $display("FAIL disabled_tick: tick %0d busy=%b star_hit=%b, want 0/0", k, busy, star_hit);
      end
    end
    checks++;
    if ({valid, h_flat, v_flat, hit_count} !== 92'd0) begin
      errors++; $display("FAIL disabled_state: valid=%b hits=%0d, want all 0", valid, hit_count);
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_collision_edge();
    test_busy_overlap();
    test_retire();
    test_full_slots();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
